// File: rtl/fibonacci_rom_checker.sv
// Sweeps a Fibonacci lookup ROM, checks every word against a locally generated term,
// and streams each word with its match flag on a valid/ready output.
module fibonacci_rom_checker #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 24,
    parameter int NUM_ENTRIES = 35
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_rdadr,
    input  logic [DATA_W-1:0] rom_rddat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_match,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   mismatch_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    // Output stream: a word transfers on any rising edge where out_valid && out_ready;
    // out_data/out_index/out_match stay frozen while out_valid is high and out_ready is low.

    typedef enum logic [1:0] {IDLE, READ, PRESENT, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] prev_q, curr_q;
    logic              launch, handshake, last, rd_mismatch;

    assign launch      = start && ((state_q == IDLE) || (state_q == DONE));
    assign handshake   = (state_q == PRESENT) && out_valid && out_ready;
    assign last        = (rom_rdadr == LAST_ADDR);
    assign rd_mismatch = (rom_rddat != curr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = READ;
            READ:       state_d = PRESENT;
            PRESENT:    if (handshake) state_d = last ? DONE : READ;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_rdadr      <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_index      <= '0;
            out_match      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_count <= '0;
            first_err_addr <= '0;
            prev_q         <= DATA_W'(1);
            curr_q         <= DATA_W'(1);
        end else begin
            if (launch) begin
                mismatch_count <= '0;
                first_err_addr <= '0;
                done           <= 1'b0;
                rom_rdadr      <= '0;
                prev_q         <= DATA_W'(1);
                curr_q         <= DATA_W'(1);
                busy           <= 1'b1;
            end
            if (state_q == READ) begin
                out_data  <= rom_rddat;
                out_index <= rom_rdadr;
                out_match <= !rd_mismatch;
                out_valid <= 1'b1;
                if (rd_mismatch) begin
                    if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
                    if (mismatch_count == '0) first_err_addr <= rom_rdadr;
                end
            end
            if (handshake) begin
                out_valid <= 1'b0;
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    rom_rdadr <= rom_rdadr + 1'b1;
                    prev_q    <= curr_q;
                    // Terms 0 and 1 are both 1, so the sum only kicks in from index 1 on.
                    if (rom_rdadr != '0) curr_q <= prev_q + curr_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_rom_checker.sv
// Self-checking bench for fibonacci_rom_checker: ROM model, Fibonacci reference model,
// expected-word queue, spot-value table and randomized backpressure/corruption rounds.
module tb_fibonacci_rom_checker;

    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 24;
    localparam int NUM_ENTRIES = 35;
    localparam int EW          = DATA_W + ADDR_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] rom_rdadr;
    logic [DATA_W-1:0] rom_rddat;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_match;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   mismatch_count;
    logic [ADDR_W-1:0] first_err_addr;

    logic [DATA_W-1:0] rom_mem  [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] fib      [0:NUM_ENTRIES-1];
    logic [DATA_W-1:0] obs_data [0:NUM_ENTRIES-1];
    logic [EW-1:0]     exp_q[$];

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
    } spot_t;
    spot_t spots [6];

    int checks = 0;
    int errors = 0;

    fibonacci_rom_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_ENTRIES(NUM_ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_rdadr(rom_rdadr), .rom_rddat(rom_rddat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_match(out_match),
        .busy(busy), .done(done),
        .mismatch_count(mismatch_count), .first_err_addr(first_err_addr)
    );

    assign rom_rddat = rom_mem[rom_rdadr];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic void build_fib();
        longint a = 1, b = 1, c;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (i < 2) fib[i] = DATA_W'(1);
            else begin
                c = (a + b) % (64'd1 << DATA_W);
                fib[i] = DATA_W'(c);
                a = b;
                b = c;
            end
        end
    endfunction

    function automatic void load_clean();
        for (int i = 0; i < (1<<ADDR_W); i++)
            rom_mem[i] = (i < NUM_ENTRIES) ? fib[i] : '0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rdadr"}, rom_rdadr, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_index"}, out_index, 0);
        check({tag, "_match"}, out_match, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mmcount"}, mismatch_count, 0);
        check({tag, "_firsterr"}, first_err_addr, 0);
    endtask

    // One sweep from a start pulse. Negative index arguments disable the respective feature.
    task automatic run_sweep(input int ready_pct, input int stall_idx, input int poke_idx,
                             input int abort_idx, input bit check_timing);
        int            cyc, stalls, first_valid, exp_mm, exp_first;
        bit            poked, aborted, got_done;
        logic [EW-1:0] e;
        exp_q.delete();
        exp_mm = 0;
        exp_first = 0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            bit m;
            m = (rom_mem[i] == fib[i]);
            exp_q.push_back({m, ADDR_W'(i), rom_mem[i]});
            if (!m) begin
                if (exp_mm == 0) exp_first = i;
                if (exp_mm < (1 << (ADDR_W + 1)) - 1) exp_mm++;
            end
        end
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        cyc = 0; stalls = 0; first_valid = -1;
        poked = 0; aborted = 0; got_done = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) check("done_cleared_on_start", done, 0);
            if (done) begin
                got_done = 1;
                break;
            end
            check("busy_in_sweep", busy, 1);
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (abort_idx >= 0 && out_index == ADDR_W'(abort_idx)) begin
                    aborted = 1;
                    break;
                end
                if (exp_q.size() == 0) begin
                    fail_now("extra_word");
                    break;
                end
                e = exp_q[0];
                check("out_data", out_data, e[DATA_W-1:0]);
                check("out_index", out_index, e[DATA_W+ADDR_W-1:DATA_W]);
                check("out_match", out_match, e[EW-1]);
                check("rdadr_hold", rom_rdadr, e[DATA_W+ADDR_W-1:DATA_W]);
                if (stall_idx >= 0 && out_index == ADDR_W'(stall_idx) && stalls < 5) begin
                    out_ready = 1'b0;
                    stalls++;
                end
                if (poke_idx >= 0 && out_index == ADDR_W'(poke_idx) && !poked) begin
                    start = 1'b1;
                    poked = 1;
                end
                if (out_ready) begin
                    obs_data[out_index] = out_data;
                    void'(exp_q.pop_front());
                end
            end
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        if (aborted) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("abort");
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("post_abort_valid", out_valid, 0);
                check("post_abort_busy", busy, 0);
            end
            return;
        end
        if (!got_done) begin
            fail_now("sweep_timeout");
            return;
        end
        check("words_left", exp_q.size(), 0);
        check("mismatch_count", mismatch_count, exp_mm);
        check("first_err_addr", first_err_addr, exp_first);
        check("busy_after_done", busy, 0);
        check("valid_after_done", out_valid, 0);
        if (check_timing) begin
            check("done_latency", cyc, 2 * NUM_ENTRIES);
            check("first_valid_latency", first_valid, 1);
        end
        @(negedge clk);
        check("done_held", done, 1);
    endtask

    initial begin
        build_fib();
        load_clean();
        spots[0] = '{0, 24'd1};
        spots[1] = '{1, 24'd1};
        spots[2] = '{2, 24'd2};
        spots[3] = '{10, 24'd89};
        spots[4] = '{20, 24'd10946};
        spots[5] = '{34, 24'd9227465};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Clean sweep, ready tied high, with timing and spot values
        run_sweep(100, -1, -1, -1, 1'b1);
        for (int i = 0; i < 6; i++)
            check($sformatf("spot_%0d", spots[i].idx), obs_data[spots[i].idx], spots[i].data);

        // Backpressure at index 3
        run_sweep(100, 3, -1, -1, 1'b0);

        // Corrupted ROM
        rom_mem[20] = '0;
        rom_mem[30] = DATA_W'(1);
        run_sweep(100, -1, -1, -1, 1'b1);
        check("corrupt_count", mismatch_count, 2);
        check("corrupt_first", first_err_addr, 20);

        // Restart from DONE with clean ROM
        load_clean();
        run_sweep(100, -1, -1, -1, 1'b1);
        check("restart_count", mismatch_count, 0);

        // start mid-sweep ignored
        run_sweep(100, -1, 12, -1, 1'b1);

        // Reset mid-sweep at index 17, then a fresh sweep
        rom_mem[5] = DATA_W'(7);
        run_sweep(100, -1, -1, 17, 1'b0);
        load_clean();
        run_sweep(100, -1, -1, -1, 1'b1);

        // Randomized rounds: random corruptions and random consumer pacing
        for (int r = 0; r < 6; r++) begin
            load_clean();
            for (int k = 0; k < int'($urandom_range(0, 5)); k++)
                rom_mem[$urandom_range(0, NUM_ENTRIES - 1)] = DATA_W'($urandom);
            run_sweep(int'($urandom_range(25, 95)), -1, -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fibonacci_rom_checker.md
Name: fibonacci_rom_checker

Overview:
Read-side sequencer and self-checker for the 24-bit Fibonacci lookup ROM. On a start pulse it walks the ROM read address from 0 to NUM_ENTRIES-1 and captures each word. It independently generates the expected Fibonacci term, with term 0 = term 1 = 1, and compares the two. Every word is presented on a valid/ready output stream, so a display or UART stage can consume it at its own pace. Mismatch statistics are kept for the lab checkout.

Parameters:
ADDR_W, 6, ROM address width
DATA_W, 24, ROM data width and expected-term width
NUM_ENTRIES, 35, number of addresses swept (0..NUM_ENTRIES-1); must be >= 2 and <= 2^ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a sweep
rom_rdadr  out  ADDR_W  read address to the ROM
rom_rddat  in  DATA_W  combinational ROM read data for rom_rdadr
out_valid  out  1  out_data/out_index/out_match hold a word
out_ready  in  1  consumer accepts the word when high with out_valid
out_data  out  DATA_W  word read from the ROM
out_index  out  ADDR_W  address the word came from
out_match  out  1  word equalled the expected term
busy  out  1  a sweep is in progress
done  out  1  sweep complete; held until the next start
mismatch_count  out  ADDR_W+1  number of mismatching words in the current or last sweep
first_err_addr  out  ADDR_W  address of the first mismatch; valid when mismatch_count != 0

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE.
  - All outputs are 0: rom_rdadr, out_*, busy, done, mismatch_count, first_err_addr.
  - Expected-term registers: prev=1, curr=1.
- States: IDLE, READ, PRESENT, DONE.
- IDLE, on start=1:
  - Clears mismatch_count, first_err_addr and done.
  - Sets rom_rdadr=0, prev=1, curr=1, busy=1.
  - Next state is READ.
- READ (exactly one cycle):
  - Registers out_data<=rom_rddat and out_index<=rom_rdadr.
  - Registers out_match<=(rom_rddat==curr).
  - Sets out_valid<=1.
  - On a mismatch, mismatch_count increments; if it was 0, first_err_addr<=rom_rdadr.
  - Next state is PRESENT.
- PRESENT:
  - out_valid and all out_* outputs are held stable until out_valid&&out_ready.
  - On the handshake cycle, out_valid<=0.
  - If rom_rdadr==NUM_ENTRIES-1: next state is DONE, busy<=0, done<=1.
  - Otherwise: rom_rdadr increments. Expected advances as prev<=curr, curr<=prev+curr, except at index 0 where curr stays 1 (term 1 is 1). Next state is READ.
- DONE:
  - done holds 1; statistics hold.
  - start=1 behaves exactly as start in IDLE.
- Latency:
  - start to first out_valid is 2 cycles.
  - With out_ready tied high, one word every 2 cycles; full sweep is 2*NUM_ENTRIES cycles from start to done.
- start while busy (READ/PRESENT) is ignored; no restart and no counter change.
- Expected-term arithmetic is modulo 2^DATA_W. No overflow flag; default parameters never overflow (term 34 = 9227465).
- mismatch_count saturates at its maximum (never wraps).
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-sweep aborts immediately to reset values; no partial word is emitted afterwards.

Test Plan:
- Correct ROM model (1,1,2,...), out_ready=1, start pulse -> 35 words at out_index 0..34 with out_data[0]=1, out_data[10]=89, out_data[34]=9227465, all out_match=1. done rises exactly 70 cycles after start. mismatch_count=0.
- Backpressure: out_ready low for 5 cycles while out_index=3 -> out_valid stays 1 and out_data stays 3 throughout. rom_rdadr does not advance until the ready cycle. Sweep then completes normally.
- Corrupted ROM: address 20 returns 0 instead of 10946, address 30 returns 1 -> out_match=0 at indices 20 and 30. Final mismatch_count=2, first_err_addr=20.
- start pulsed at index 12 mid-sweep -> ignored; sequence continues from 13 and done asserts once.
- rst_n dropped while out_index=17, released, then start -> outputs are 0 during reset. New sweep begins at index 0 with cleared statistics.
- Restart from DONE after the corrupted run with a clean ROM -> done clears on start, mismatch_count returns to 0, and 35 matching words are emitted.
